dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter and access sequencer in front of the single-port 128-word `data_memory`. It lets the CPU memory stage (port 0) and a loader/debug master (port 1) share the memory through a request/grant handshake. Each accepted request becomes one registered memory access, and the arbiter returns read data or an error to the winner. The block sits between the requesters and `data_memory` and is the only driver of the memory's `address`/`writeData`/`memWrite`/`memRead` inputs.

## Interface
- DEPTH, 128, memory depth in words; legal word addresses are 0..DEPTH-1
- DATA_W, 32, data width
- ADDR_W, 32, requester and memory address width
- clock_in  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  reset, synchronous and active-low
- req0 / req1  input  1  access request from port 0 / port 1
- we0 / we1  input  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  input  ADDR_W  word address
- wdata0 / wdata1  input  DATA_W  write data
- gnt0 / gnt1  output  1  one-cycle pulse: request latched
- rvalid0 / rvalid1  output  1  one-cycle pulse: access completed
- rdata0 / rdata1  output  DATA_W  read data, valid with rvalid on reads; 0 otherwise
- err0 / err1  output  1  one-cycle pulse with rvalid: address out of range
- mem_address  output  ADDR_W  to memory `address`
- mem_writeData  output  DATA_W  to memory `writeData`
- mem_memWrite  output  1  to memory `memWrite`
- mem_memRead  output  1  to memory `memRead`
- mem_readData  input  DATA_W  from memory `readData` (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when req0 | req1.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Requests are sampled only in IDLE.
- Winner selection in IDLE:
  - If only one req is high, that port wins.
  - If both are high, the port not served last wins. The last-served pointer `last` updates on every grant.
- On IDLE → ACCESS the block latches port, we, addr and wdata. In_range = (addr < DEPTH), using the full ADDR_W compare.
- In ACCESS:
  - gnt of the winner is high.
  - mem_address = latched addr; mem_writeData = latched wdata.
  - mem_memWrite = we & in_range; mem_memRead = ~we & in_range.
- In every other state all mem_* outputs are 0.
- On ACCESS → RESP:
  - Reads: rdata ← in_range ? mem_readData : 0.
  - Writes: rdata ← 0.
  - err ← ~in_range.
- In RESP: rvalid of the winner is high, err as latched. The other port's outputs stay 0.
- Requester rule: hold req, we, addr and wdata stable until gnt is seen, and drop req no later than the RESP cycle. A req still high in the next IDLE is treated as a new request.
- An out-of-range access never asserts mem_memWrite or mem_memRead.

## Timing
- All outputs are registered.
- Reset values: state = IDLE, last = 1 (port 0 wins the first tie), all gnt/rvalid/err = 0, rdata = 0, all mem_* = 0.
- Latency: req sampled high in IDLE at edge N → gnt and mem_* active in cycle N+1 → rvalid in cycle N+2 → IDLE in cycle N+3. Throughput is one access per 3 cycles.
- The memory writes on the falling edge inside the ACCESS cycle, and mem_* stay stable for the whole cycle. Read data is captured at the rising edge that ends ACCESS.
- Simultaneous requests: exactly one gnt per ACCESS. The loser keeps req high and wins in the next IDLE.
- Reset mid-operation:
  - Reset sampled low at an edge puts the block in its reset state at that edge.
  - A write whose ACCESS cycle has already seen its falling edge is complete. No rvalid is issued for the aborted transaction.

## Structure
- Package `dmem_arb_pkg`:
  - state encoding: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10
  - default DEPTH / DATA_W / ADDR_W constants
- Sub-module `rr_arb2`: combinational 2-way round-robin pick (inputs req0, req1, last; output winner index and valid).
- The FSM, request latch, memory drive and response registers live in `dmem_arbiter`.

## Test plan
- Single read: memFile[5] = 32'hDEAD_BEEF; req0, we0 = 0, addr0 = 5.
  - gnt0 one cycle later with mem_memRead = 1, mem_address = 5.
  - rvalid0 next cycle with rdata0 = 32'hDEAD_BEEF, err0 = 0.
- Write then read: port 1 writes 32'h1234_5678 to address 10, then reads address 10.
  - The write pulses rvalid1 with rdata1 = 0.
  - The read returns 32'h1234_5678.
- Contention: req0 and req1 held high continuously from reset.
  - Grant order is 0, 1, 0, 1.
  - Grants are 3 cycles apart with no gnt overlap.
- Out of range: req0, we0 = 1, addr0 = 128.
  - mem_memWrite stays 0 throughout.
  - rvalid0 and err0 pulse together.
  - A subsequent read of address 0 is unaffected.
- Reset mid-access: reset_n low at the edge ending ACCESS of a read.
  - Next cycle: state IDLE, rvalid0 = 0, all mem_* = 0.
  - First tie after release goes to port 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and default sizing for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick
//   req0, req1 : requests
//   last       : port served most recently (loses a tie)
//   winner     : chosen port index
//   valid      : at least one request present
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);
    always_comb begin
        winner = (req0 & req1) ? ~last : req1;
        valid  = req0 | req1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and access sequencer for a single-port data memory
//   clock_in, reset_n              : clock, synchronous active-low reset
//   req/we/addr/wdata [0,1]        : requester side access requests
//   gnt/rvalid/rdata/err [0,1]     : grant pulse, completion pulse, read data, range error
//   mem_address/writeData/memWrite/memRead : registered memory drive
//   mem_readData                   : combinational memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData
);
    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               port_q, port_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               in_range_q, in_range_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         rvalid_q, rvalid_d;
    logic [1:0]         err_q, err_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [DATA_W-1:0]  mem_writeData_q, mem_writeData_d;
    logic               mem_memWrite_q, mem_memWrite_d;
    logic               mem_memRead_q, mem_memRead_d;
    logic               win, win_valid;
    logic               sel_we, sel_in_range;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata, rd_data;

    rr_arb2 u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (win),
        .valid  (win_valid)
    );

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        port_d          = port_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        in_range_d      = in_range_q;
        gnt_d           = '0;
        rvalid_d        = '0;
        err_d           = '0;
        rdata0_d        = '0;
        rdata1_d        = '0;
        mem_address_d   = '0;
        mem_writeData_d = '0;
        mem_memWrite_d  = 1'b0;
        mem_memRead_d   = 1'b0;
        sel_we          = win ? we1 : we0;
        sel_addr        = win ? addr1 : addr0;
        sel_wdata       = win ? wdata1 : wdata0;
        sel_in_range    = sel_addr < ADDR_W'(DEPTH);
        rd_data         = (~we_q & in_range_q) ? mem_readData : '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d         = ACCESS;
                    last_d          = win;
                    port_d          = win;
                    we_d            = sel_we;
                    addr_d          = sel_addr;
                    wdata_d         = sel_wdata;
                    in_range_d      = sel_in_range;
                    gnt_d[win]      = 1'b1;
                    // memory drive is registered, so it is loaded here to be valid throughout ACCESS
                    mem_address_d   = sel_addr;
                    mem_writeData_d = sel_wdata;
                    mem_memWrite_d  = sel_we & sel_in_range;
                    mem_memRead_d   = ~sel_we & sel_in_range;
                end
            end
            ACCESS: begin
                state_d          = RESP;
                rvalid_d[port_q] = 1'b1;
                err_d[port_q]    = ~in_range_q;
                rdata0_d         = port_q ? '0 : rd_data;
                rdata1_d         = port_q ? rd_data : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            last_q          <= 1'b1;
            port_q          <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            in_range_q      <= 1'b0;
            gnt_q           <= '0;
            rvalid_q        <= '0;
            err_q           <= '0;
            rdata0_q        <= '0;
            rdata1_q        <= '0;
            mem_address_q   <= '0;
            mem_writeData_q <= '0;
            mem_memWrite_q  <= 1'b0;
            mem_memRead_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            port_q          <= port_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            in_range_q      <= in_range_d;
            gnt_q           <= gnt_d;
            rvalid_q        <= rvalid_d;
            err_q           <= err_d;
            rdata0_q        <= rdata0_d;
            rdata1_q        <= rdata1_d;
            mem_address_q   <= mem_address_d;
            mem_writeData_q <= mem_writeData_d;
            mem_memWrite_q  <= mem_memWrite_d;
            mem_memRead_q   <= mem_memRead_d;
        end
    end

    assign gnt0          = gnt_q[0];
    assign gnt1          = gnt_q[1];
    assign rvalid0       = rvalid_q[0];
    assign rvalid1       = rvalid_q[1];
    assign err0          = err_q[0];
    assign err1          = err_q[1];
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_writeData_q;
    assign mem_memWrite  = mem_memWrite_q;
    assign mem_memRead   = mem_memRead_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural 128-word memory
module tb_dmem_arbiter;
    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;

    logic [31:0] mem_file [128] = '{0: 32'hA5A5_0000, 1: 32'h1111_1111, 2: 32'h2222_2222,
                                    3: 32'h3333_3333, 4: 32'h4444_4444, 5: 32'hDEAD_BEEF, default: 32'h0};
    logic [31:0] model    [128] = '{0: 32'hA5A5_0000, 1: 32'h1111_1111, 2: 32'h2222_2222,
                                    3: 32'h3333_3333, 4: 32'h4444_4444, 5: 32'hDEAD_BEEF, default: 32'h0};

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_memWrite) mem_file[mem_address[6:0]] <= mem_writeData;
    assign mem_readData = mem_file[mem_address[6:0]];

    dmem_arbiter dut (
        .clock_in      (clk),
        .reset_n       (reset_n),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rvalid0       (rvalid0),
        .rvalid1       (rvalid1),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .err0          (err0),
        .err1          (err1),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memWrite  (mem_memWrite),
        .mem_memRead   (mem_memRead),
        .mem_readData  (mem_readData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            exp_t e;
            chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
            if (sb.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("rsp_port", 32'(rvalid1), 32'(e.port));
                chk("rsp_rdata", rvalid1 ? rdata1 : rdata0, e.rdata);
                chk("rsp_err", 32'(rvalid1 ? err1 : err0), 32'(e.err));
                chk("rsp_other_rdata", rvalid1 ? rdata0 : rdata1, 32'd0);
            end
        end
    end

    task automatic txn(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic ir;
        int   n;
        exp_t e;
        ir      = a < 32'd128;
        e.port  = p;
        e.err   = ~ir;
        e.rdata = (w || !ir) ? 32'd0 : model[a[6:0]];
        if (w && ir) model[a[6:0]] = d;
        sb.push_back(e);
        @(negedge clk);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(p ? gnt1 : gnt0) && n < 10);
        chk("gnt_latency", n, 32'd1);
        chk("gnt_other", 32'(p ? gnt0 : gnt1), 32'd0);
        chk("mem_write", 32'(mem_memWrite), 32'(w && ir));
        chk("mem_read", 32'(mem_memRead), 32'(!w && ir));
        chk("mem_addr", mem_address, a);
        chk("mem_wdata", mem_writeData, d);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("rvalid_lat", 32'(p ? rvalid1 : rvalid0), 32'd1);
        chk("resp_mem_quiet", 32'(mem_memWrite | mem_memRead), 32'd0);
        @(negedge clk);
        chk("idle_quiet", 32'(rvalid0 | rvalid1 | gnt0 | gnt1), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int g_cnt, last_cyc;
        logic exp_port;
        reset_n = 1'b0;
        {req0, req1, we0, we1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_err", 32'({err1, err0}), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_ctl", 32'({mem_memWrite, mem_memRead}), 32'd0);
        reset_n = 1'b1;

        txn(1'b0, 1'b0, 32'd5, 32'd0);
        txn(1'b1, 1'b1, 32'd10, 32'h1234_5678);
        txn(1'b1, 1'b0, 32'd10, 32'd0);
        chk("mem_written", mem_file[10], 32'h1234_5678);
        txn(1'b0, 1'b1, 32'd128, 32'hFFFF_FFFF);
        txn(1'b0, 1'b0, 32'd0, 32'd0);
        txn(1'b1, 1'b0, 32'h8000_0005, 32'd0);
        txn(1'b0, 1'b0, 32'd127, 32'd0);

        // contention from reset: both ports reading continuously
        @(negedge clk);
        reset_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
        for (int i = 0; i < 4; i++) sb.push_back('{port: i[0], rdata: model[i[0] ? 2 : 1], err: 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        g_cnt = 0;
        last_cyc = 0;
        exp_port = 1'b0;
        for (int c = 0; c < 20 && g_cnt < 4; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) chk("gnt_overlap", 32'd1, 32'd0);
            if (gnt0 || gnt1) begin
                chk("grant_order", 32'(gnt1), 32'(exp_port));
                if (g_cnt == 0) chk("first_grant_cycle", c, 32'd0);
                else chk("grant_spacing", c - last_cyc, 32'd3);
                last_cyc = c;
                exp_port = ~exp_port;
                g_cnt++;
                if (g_cnt == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        chk("grant_count", g_cnt, 32'd4);
        repeat (3) @(negedge clk);

        // reset at the edge ending ACCESS of a port-0 read
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt0), 32'd1);
        reset_n = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        chk("abort_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("abort_mem_ctl", 32'({mem_memWrite, mem_memRead}), 32'd0);
        chk("abort_mem_addr", mem_address, 32'd0);
        chk("abort_rdata0", rdata0, 32'd0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        sb.push_back('{port: 1'b0, rdata: model[3], err: 1'b0});
        reset_n = 1'b1;
        @(negedge clk);
        chk("tie_after_reset", 32'({gnt1, gnt0}), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
